// File: rtl/execute_muldiv_sequencer_if.sv
// Execute-stage bundle between the pipeline and the M-extension sequencer.
//
// Handshake: StartE is a level. It is accepted only while the sequencer
// is idle and FlushE is low. From the accept cycle until the result is
// ready the sequencer holds StallMD high, which freezes F/D/E. DoneE is a
// one-cycle pulse. MulDivResultE is valid in that cycle and holds its value
// until the next DoneE. FlushE kills the op in flight, and no DoneE follows.
interface execute_muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            StartE;
  logic [2:0]      MulDivOpE;
  logic [XLEN-1:0] SrcAE;
  logic [XLEN-1:0] SrcBE;
  logic            FlushE;
  logic            StallMD;
  logic            DoneE;
  logic [XLEN-1:0] MulDivResultE;

  modport master (
    output StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
    input  StallMD, DoneE, MulDivResultE
  );

  modport slave (
    input  StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
    output StallMD, DoneE, MulDivResultE
  );
endinterface

// File: rtl/execute_muldiv_sequencer.sv
// Iterative RV32M sequencer. The multiplier is shift-add and the divider is
// restoring; each retires one bit per cycle. Both work on magnitudes, and the
// sign fix-up is applied on the edge that enters DONE.
module execute_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  execute_muldiv_sequencer_if.slave     bus,
  output logic [1:0]                    o_state
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;    // product (mul); upper half is remainder (div)
  logic [XLEN-1:0]   r_quot;
  logic [XLEN-1:0]   r_a;      // |A|: multiplicand, or dividend shifting left
  logic [XLEN-1:0]   r_b;      // |B|: multiplier shifting right, or divisor
  logic [2:0]        r_op;
  logic              r_sa;
  logic              r_sb;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  logic              w_sa, w_sb, w_accept, w_special;
  logic [XLEN-1:0]   w_abs_a, w_abs_b, w_special_res;
  logic [XLEN:0]     w_mul_sum, w_div_sh, w_div_diff;
  logic              w_div_borrow;
  logic [2*XLEN-1:0] w_mul_acc, w_prod;
  logic [XLEN-1:0]   w_div_rem, w_div_quot, w_quot_f, w_rem_f, w_final_res;

  // Operand decode, special-divide detection, and one iteration of each datapath
  always_comb begin
    w_sa          = 1'b0;
    w_sb          = 1'b0;
    w_special     = 1'b0;
    w_special_res = '0;
    case (bus.MulDivOpE)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        w_sa = bus.SrcAE[XLEN-1];
        w_sb = bus.SrcBE[XLEN-1];
      end
      3'b010:  w_sa = bus.SrcAE[XLEN-1];
      default: ;
    endcase
    w_abs_a  = w_sa ? (~bus.SrcAE + 1'b1) : bus.SrcAE;
    w_abs_b  = w_sb ? (~bus.SrcBE + 1'b1) : bus.SrcBE;
    w_accept = bus.StartE && !bus.FlushE;
    if (bus.MulDivOpE[2] && (bus.SrcBE == '0)) begin
      w_special     = 1'b1;
      w_special_res = bus.MulDivOpE[1] ? bus.SrcAE : '1;
    end else if (bus.MulDivOpE[2] && !bus.MulDivOpE[0] &&
                 (bus.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) && (bus.SrcBE == '1)) begin
      w_special     = 1'b1;
      w_special_res = bus.MulDivOpE[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    w_mul_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : '0);
    w_mul_acc    = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_sh     = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
    w_div_borrow = w_div_sh < {1'b0, r_b};
    w_div_diff   = w_div_sh - {1'b0, r_b};
    w_div_rem    = w_div_borrow ? w_div_sh[XLEN-1:0] : w_div_diff[XLEN-1:0];
    w_div_quot   = {r_quot[XLEN-2:0], ~w_div_borrow};

    w_prod   = (r_sa ^ r_sb) ? (~w_mul_acc + 1'b1) : w_mul_acc;
    w_quot_f = (r_sa ^ r_sb) ? (~w_div_quot + 1'b1) : w_div_quot;
    w_rem_f  = r_sa ? (~w_div_rem + 1'b1) : w_div_rem;
    case (r_op)
      3'b000:                 w_final_res = w_prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final_res = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final_res = w_quot_f;
      default:                w_final_res = w_rem_f;
    endcase
  end

  // Sequencer FSM with its datapath registers and registered result/done
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_quot   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op   <= bus.MulDivOpE;
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_a    <= w_abs_a;
            r_b    <= w_abs_b;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_quot <= '0;
            if (w_special) begin
              r_result <= w_special_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.FlushE) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op[2]) begin
              r_acc[2*XLEN-1:XLEN] <= w_div_rem;
              r_a                  <= r_a << 1;
              r_quot               <= w_div_quot;
            end else begin
              r_acc <= w_mul_acc;
              r_b   <= r_b >> 1;
            end
            if (r_cnt == CW'(XLEN-1)) begin
              r_result <= w_final_res;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.StallMD       = ((r_state == IDLE) && w_accept) || (r_state == BUSY);
  assign bus.DoneE         = r_done;
  assign bus.MulDivResultE = r_result;
  assign o_state           = r_state;
endmodule

// File: tb/tb_execute_muldiv_sequencer.sv
// Bench for execute_muldiv_sequencer. Expected results are queued at issue
// and compared whenever DoneE fires.
module tb_execute_muldiv_sequencer;
  localparam int XLEN = 32;

  logic        clk;
  logic        reset;
  logic [1:0]  dbg_state;
  int          n_vec;
  int          n_err;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;
  logic [31:0] exp_v;

  execute_muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  execute_muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .o_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every DoneE pops one expected result
  always @(negedge clk) begin
    if (!reset && bus.DoneE) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check("result", {32'd0, bus.MulDivResultE}, {32'd0, exp_v});
        last_res = exp_v;
      end
    end
  end

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // Drive cycle 0 of an op; operands are scrambled afterwards
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.StartE    = 1'b1;
    bus.MulDivOpE = op;
    bus.SrcAE     = a;
    bus.SrcBE     = b;
    #1;
    check("stall_c0", {63'd0, bus.StallMD}, 64'd1);
    check("done_c0", {63'd0, bus.DoneE}, 64'd0);
    @(posedge clk); #1;
    bus.StartE = 1'b0;
    bus.SrcAE  = $urandom;
    bus.SrcBE  = $urandom;
  endtask

  // Full op: queue the expected value and track stall/latency to DoneE
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    exp_q.push_back(exp_res);
    start_op(op, a, b);
    lat = 1;
    while (!bus.DoneE && lat < 100) begin
      if (bus.StallMD !== 1'b1) check("stall_busy", {63'd0, bus.StallMD}, 64'd1);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("stall_done", {63'd0, bus.StallMD}, 64'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    n_vec = 0;
    n_err = 0;
    last_res = '0;
    reset = 1'b1;
    bus.StartE = 1'b0;
    bus.FlushE = 1'b0;
    bus.MulDivOpE = '0;
    bus.SrcAE = '0;
    bus.SrcBE = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_stall", {63'd0, bus.StallMD}, 64'd0);
    check("rst_done", {63'd0, bus.DoneE}, 64'd0);
    check("rst_result", {32'd0, bus.MulDivResultE}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);

    // multiplies
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    // divides
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33);
    // special divides
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // random ops against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 28);
      run_op(rop, ra, rb, model(rop, ra, rb), exp_latency(rop, ra, rb));
    end

    // flush mid-BUSY: no DoneE, result held
    start_op(3'd0, 32'd5, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_state", {62'd0, dbg_state}, 64'd1);
    bus.FlushE = 1'b1;
    @(posedge clk); #1;
    bus.FlushE = 1'b0;
    check("flush_state", {62'd0, dbg_state}, 64'd0);
    check("flush_stall", {63'd0, bus.StallMD}, 64'd0);
    check("flush_done", {63'd0, bus.DoneE}, 64'd0);
    check("flush_result", {32'd0, bus.MulDivResultE}, {32'd0, last_res});
    repeat (40) @(posedge clk);
    #1;
    check("flush_idle", {62'd0, dbg_state}, 64'd0);
    run_op(3'd0, 32'd11, 32'd13, 32'd143, 33);

    // back-to-back ops
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 33);
    run_op(3'd5, 32'd9, 32'd3, 32'd3, 33);

    // reset mid-op
    start_op(3'd0, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_stall", {63'd0, bus.StallMD}, 64'd0);
    check("mid_rst_done", {63'd0, bus.DoneE}, 64'd0);
    check("mid_rst_result", {32'd0, bus.MulDivResultE}, 64'd0);
    check("mid_rst_state", {62'd0, dbg_state}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/execute_muldiv_sequencer.md
# execute_muldiv_sequencer

Multi-cycle controller that sequences RISC-V M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) for the Execute stage. It uses an iterative shift-add multiplier and a restoring divider, one bit per cycle. It takes the forwarded operands SrcAE/SrcBE, holds the Execute stage through StallMD while it iterates, and delivers a registered result that Execute selects in place of ALUResultE on DoneE. It sits beside the ALU in Execute and feeds StallMD into the Hazard Unit.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- StartE  in  1  valid M-extension instruction currently in Execute
- MulDivOpE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcAE  in  XLEN  forwarded rs1 operand
- SrcBE  in  XLEN  forwarded rs2 operand
- FlushE  in  1  kill the instruction in Execute (taken branch/jump)
- StallMD  out  1  to Hazard Unit: freeze F/D/E, bubble into M
- DoneE  out  1  one-cycle pulse, MulDivResultE valid for the instruction in Execute
- MulDivResultE  out  XLEN  registered result, held until next DONE

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, StartE=1, FlushE=0:
  - Latch op, operand signs and magnitudes. Signed ops take the absolute value of signed operands; MULHSU treats only A as signed.
  - Clear counter, accumulator and quotient.
  - Go to BUSY. Special divides go directly to DONE instead (see below).
- BUSY: one iteration per cycle.
  - Multiply: if the multiplier LSB is set, add the multiplicand into the upper half of the 2·XLEN accumulator, then shift right.
  - Divide: shift the remainder left, bring in the next dividend MSB, subtract the divisor, and restore if the result is negative. The quotient bit is the inverse of the borrow.
  - After XLEN iterations (counter == XLEN-1), go to DONE.
- DONE: write MulDivResultE, assert DoneE, always go to IDLE. StartE is ignored in DONE, because the same instruction is still in E.
- Sign fix-up, applied on entry to DONE:
  - Multiply: negate the 2·XLEN product if sA^sB (MULHSU: sA only).
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
  - DIV: negate the quotient if sA^sB. REM: negate the remainder if sA.
- Special cases, detected in IDLE; the FSM goes to DONE after one cycle:
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → SrcAE.
  - DIV of 0x80000000 by 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- StallMD = (state==IDLE && StartE && !FlushE) || state==BUSY. It is deasserted in DONE so the instruction advances to M with the result.
- FlushE in any state: next state IDLE, no DoneE, MulDivResultE unchanged. FlushE has priority over StartE.
- reset: state IDLE, counter/accumulator/quotient 0, MulDivResultE 0, DoneE 0, StallMD 0.

## Timing
- Cycle 0: StartE seen in IDLE, StallMD=1 combinationally, operands latched at the edge.
- Cycles 1..XLEN: BUSY, StallMD=1.
- Cycle XLEN+1: DONE, StallMD=0, DoneE=1, MulDivResultE valid.
- Normal latency: XLEN+2 cycles in E (34 for XLEN=32). Special divides take 2 cycles (IDLE stall, DONE).
- MulDivResultE is registered. It updates on the edge entering DONE and holds afterwards.
- Back-to-back M ops: the second op's StartE in the cycle after DONE is accepted from IDLE. There are no dead cycles other than that.
- Operand changes on SrcAE/SrcBE after cycle 0 are ignored, since operands are latched.
- reset asserted mid-BUSY: IDLE on the next edge, StallMD=0 that cycle.

## Test plan
- MUL 7 × -3 → DoneE exactly 33 cycles after start, MulDivResultE=0xFFFFFFEB, StallMD high cycles 0..32 and low at 33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD and REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14 and REMU 100/7 → 2, each at 34-cycle latency.
- DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5. DIV 0x80000000/-1 → 0x80000000. Each gives DoneE on the cycle after start (2-cycle latency).
- FlushE at BUSY iteration 10 → IDLE next cycle, StallMD=0, no DoneE, MulDivResultE keeps its prior value. A following StartE runs a full new op.
- Back-to-back MUL 3×4 then DIVU 9/3 → results 12 then 3, the second starting the cycle after the first DoneE. Reset pulse mid-second op → all outputs 0 next cycle.
